// File: rtl/floppy_pkg.sv
// floppy_pkg: shared state encoding, spindle timing constants and helpers
// for the drive-interface blocks.
package floppy_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam int unsigned CLK_HZ        = 10_000_000;
   // nominal 360 rpm revolution at CLK_HZ and its +/-5% window
   localparam logic [23:0] RPM_360_PERIOD = 24'd1666667;
   localparam logic [23:0] MIN_PERIOD_DEF = 24'd1583333;
   localparam logic [23:0] MAX_PERIOD_DEF = 24'd1750000;
   localparam logic [23:0] TIMEOUT_DEF    = 24'd3333334;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction
endpackage

// File: rtl/index_edge_det.sv
// index_edge_det: rising-edge detector on the synchronous INDEX level with a
// combinational rise and a registered, gated pulse.
module index_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic in,
   input  logic en,
   output logic rise,
   output logic pulse
);
   logic idx_dly_q;
   logic pulse_q;

   assign rise  = in & ~idx_dly_q;
   assign pulse = pulse_q;

   // idx_dly starts high so an index already asserted at reset release is ignored
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         idx_dly_q <= 1'b1;
         pulse_q   <= 1'b0;
      end else begin
         idx_dly_q <= in;
         pulse_q   <= rise & en;
      end
endmodule

// File: rtl/index_period_monitor.sv
// index_period_monitor: measures spindle rotation period from INDEX edges,
// qualifies speed stability (ready) and flags missing index (timeout).
module index_period_monitor
   import floppy_pkg::*;
#(
   parameter int               CNT_W       = 24,
   parameter logic [CNT_W-1:0] MIN_PERIOD  = CNT_W'(MIN_PERIOD_DEF),
   parameter logic [CNT_W-1:0] MAX_PERIOD  = CNT_W'(MAX_PERIOD_DEF),
   parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF),
   parameter int               STABLE_REVS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             index_in,
   output logic             index_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             ready,
   output logic             timeout
);
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] period_q;
   logic [3:0]       stable_q;
   logic             pv_q;
   logic             ready_q;
   logic             timeout_q;
   logic             rise;
   logic             in_win;
   logic             at_to;
   logic [3:0]       stable_d;
   logic [CNT_W-1:0] cnt_d;

   index_edge_det u_edge (
      .clk   (clk),
      .reset (reset),
      .in    (index_in),
      .en    (enable && state_q != IDLE),
      .rise  (rise),
      .pulse (index_pulse)
   );

   assign in_win   = cnt_q >= MIN_PERIOD && cnt_q <= MAX_PERIOD;
   assign at_to    = cnt_q == TIMEOUT;
   assign stable_d = in_win ? sat_inc(stable_q) : 4'd0;
   assign cnt_d    = at_to ? cnt_q : cnt_q + CNT_W'(1);

   assign period       = period_q;
   assign period_valid = pv_q;
   assign ready        = ready_q;
   assign timeout      = timeout_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         stable_q  <= '0;
         pv_q      <= 1'b0;
         ready_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         pv_q <= 1'b0;
         if (!enable) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stable_q  <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: state_q <= SYNC;
               SYNC:
                  if (rise) begin
                     cnt_q     <= CNT_W'(1);
                     timeout_q <= 1'b0;
                     state_q   <= MEASURE;
                  end else begin
                     cnt_q <= cnt_d;
                     if (at_to) timeout_q <= 1'b1;
                  end
               MEASURE:
                  // a rise coinciding with the timeout count still reports its period
                  if (rise) begin
                     period_q <= cnt_q;
                     pv_q     <= 1'b1;
                     cnt_q    <= CNT_W'(1);
                     stable_q <= stable_d;
                     ready_q  <= in_win && stable_d >= 4'(STABLE_REVS);
                  end else if (at_to) begin
                     timeout_q <= 1'b1;
                     ready_q   <= 1'b0;
                     stable_q  <= '0;
                     state_q   <= SYNC;
                  end else
                     cnt_q <= cnt_d;
               default: state_q <= IDLE;
            endcase
         end
      end
endmodule

// File: tb/tb_index_period_monitor.sv
// tb_index_period_monitor: directed checks of edge strobes, period measurement,
// stability window, timeout and enable/reset behaviour with small parameters.
module tb_index_period_monitor;
   logic       clk;
   logic       reset;
   logic       enable;
   logic       index_in;
   logic       index_pulse;
   logic [7:0] period;
   logic       period_valid;
   logic       ready;
   logic       timeout;
   int         tests;
   int         fails;
   int         pulse_cnt;

   index_period_monitor #(
      .CNT_W       (8),
      .MIN_PERIOD  (8'd40),
      .MAX_PERIOD  (8'd60),
      .TIMEOUT     (8'd100),
      .STABLE_REVS (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .index_in     (index_in),
      .index_pulse  (index_pulse),
      .period       (period),
      .period_valid (period_valid),
      .ready        (ready),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial pulse_cnt = 0;
   always @(negedge clk) if (index_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one-cycle index hole; returns just after the edge that sees the rise
   task automatic hole();
      index_in = 1'b1;
      tick();
      index_in = 1'b0;
   endtask

   task automatic gap_hole(input int p);
      repeat (p - 1) tick();
      hole();
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      enable   = 1'b1;
      index_in = 1'b1;
      repeat (3) tick();
      chk("rst_ready", ready, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_period", period, 0);
      chk("rst_pv", period_valid, 0);
      chk("rst_pulse", index_pulse, 0);
      reset = 1'b0;
      repeat (101) tick();
      chk("sync_timeout_early", timeout, 0);
      tick();
      chk("sync_timeout", timeout, 1);
      chk("high_at_release_no_pulse", pulse_cnt, 0);

      index_in = 1'b0;
      tick();
      hole();
      chk("first_edge_pulse", index_pulse, 1);
      chk("first_edge_no_pv", period_valid, 0);
      chk("first_edge_clr_timeout", timeout, 0);
      tick();
      chk("pulse_one_cycle", index_pulse, 0);
      gap_hole(49);
      chk("p50_pv", period_valid, 1);
      chk("p50_period", period, 50);
      chk("p50_pulse", index_pulse, 1);
      chk("p50_ready0", ready, 0);
      tick();
      chk("pv_one_cycle", period_valid, 0);
      gap_hole(49);
      chk("rev3_ready0", ready, 0);
      gap_hole(50);
      chk("rev4_ready1", ready, 1);
      chk("rev4_period", period, 50);

      gap_hole(70);
      chk("gap70_period", period, 70);
      chk("gap70_ready0", ready, 0);
      gap_hole(50);
      gap_hole(50);
      chk("after70_2_ready0", ready, 0);
      gap_hole(50);
      chk("after70_3_ready1", ready, 1);

      gap_hole(40);
      chk("p40_period", period, 40);
      chk("p40_ready", ready, 1);
      gap_hole(60);
      chk("p60_ready", ready, 1);
      gap_hole(39);
      chk("p39_period", period, 39);
      chk("p39_ready0", ready, 0);
      gap_hole(40);
      gap_hole(60);
      chk("p40_60_ready0", ready, 0);
      gap_hole(50);
      chk("limits_count_ready1", ready, 1);
      gap_hole(61);
      chk("p61_period", period, 61);
      chk("p61_ready0", ready, 0);
      gap_hole(50);
      gap_hole(50);
      gap_hole(50);
      chk("after61_ready1", ready, 1);

      repeat (99) tick();
      chk("stop_timeout_early", timeout, 0);
      chk("stop_ready_early", ready, 1);
      tick();
      chk("stop_timeout", timeout, 1);
      chk("stop_ready0", ready, 0);
      repeat (5) tick();
      hole();
      chk("resync_timeout0", timeout, 0);
      chk("resync_no_pv", period_valid, 0);
      chk("resync_pulse", index_pulse, 1);
      gap_hole(100);
      chk("rise_at_to_pv", period_valid, 1);
      chk("rise_at_to_period", period, 100);
      chk("rise_at_to_timeout0", timeout, 0);
      chk("rise_at_to_ready0", ready, 0);

      gap_hole(50);
      gap_hole(50);
      gap_hole(50);
      chk("pre_dis_ready1", ready, 1);
      repeat (20) tick();
      enable = 1'b0;
      tick();
      chk("dis_ready0", ready, 0);
      chk("dis_period_kept", period, 50);
      hole();
      chk("idle_no_pulse", index_pulse, 0);
      chk("idle_no_pv", period_valid, 0);
      enable = 1'b1;
      tick();
      hole();
      chk("reen_sync_no_pv", period_valid, 0);
      chk("reen_sync_pulse", index_pulse, 1);
      gap_hole(50);
      chk("reen_p1_pv", period_valid, 1);
      gap_hole(50);
      chk("reen_p2_ready0", ready, 0);
      gap_hole(50);
      chk("reen_p3_ready1", ready, 1);

      repeat (10) tick();
      #2 reset = 1'b1;
      #1;
      chk("async_rst_ready", ready, 0);
      chk("async_rst_period", period, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_timeout", timeout, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
